// File: rtl/alarm_unit_bcd_if.sv
// Bus between the time core / user controls and the daily alarm stage.
// The master drives time, pulses and levels; the slave returns alarm time and buzzer status.
interface alarm_unit_bcd_if;
  logic [23:0] time_bcd24;
  logic        sec_pulse;
  logic        alarm_en;
  logic        alarm_set;
  logic        inc_h_pulse;
  logic        inc_m_pulse;
  logic        snooze_pulse;
  logic        stop_pulse;
  logic [15:0] alarm_bcd16;
  logic        buzzer;
  logic        ringing;
  logic        snoozing;

  modport master (
    output time_bcd24, sec_pulse, alarm_en, alarm_set,
           inc_h_pulse, inc_m_pulse, snooze_pulse, stop_pulse,
    input  alarm_bcd16, buzzer, ringing, snoozing
  );

  modport slave (
    input  time_bcd24, sec_pulse, alarm_en, alarm_set,
           inc_h_pulse, inc_m_pulse, snooze_pulse, stop_pulse,
    output alarm_bcd16, buzzer, ringing, snoozing
  );
endinterface

// File: rtl/alarm_unit_bcd.sv
// Daily alarm stage: compares 24h BCD time to a user-set HH:MM and drives a beeping buzzer
// with snooze, stop and auto-silence, all timed from the core's 1 Hz pulse.
module alarm_unit_bcd #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter bit TONE_EN    = 1'b1
) (
  input logic              clk_ac,
  input logic              rst_n,
  alarm_unit_bcd_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_MIN * 60);
  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

  function automatic logic [7:0] inc_hour(input logic [7:0] h);
    if (h == 8'h23)       return 8'h00;
    if (h[3:0] == 4'h9)   return {h[7:4] + 4'h1, 4'h0};
    return {h[7:4], h[3:0] + 4'h1};
  endfunction

  // Minutes wrap 59 -> 00 without carrying into the hour.
  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m == 8'h59)       return 8'h00;
    if (m[3:0] == 4'h9)   return {m[7:4] + 4'h1, 4'h0};
    return {m[7:4], m[3:0] + 4'h1};
  endfunction

  state_t     state, state_nxt;
  logic [7:0] alarm_h, alarm_h_nxt;
  logic [7:0] alarm_m, alarm_m_nxt;
  logic [7:0] ring_cnt, ring_nxt;
  logic [9:0] snz_cnt, snz_nxt;
  logic       beep_on, beep_nxt;
  logic       tone, tone_nxt;
  logic       buzzer_nxt;
  logic       buzzer_q, ringing_q, snoozing_q;
  logic       trig, cancel;

  assign trig   = bus.sec_pulse
                & (bus.time_bcd24[23:8] == {alarm_h, alarm_m})
                & (bus.time_bcd24[7:0] == 8'h00);
  assign cancel = bus.alarm_set | ~bus.alarm_en;

  always_comb begin
    // NOTE: every value written here gets a default first, so no latch is inferred.
    alarm_h_nxt = alarm_h;
    alarm_m_nxt = alarm_m;
    state_nxt   = state;
    ring_nxt    = ring_cnt;
    snz_nxt     = snz_cnt;
    beep_nxt    = beep_on;

    if (bus.alarm_set) begin
      if (bus.inc_h_pulse) alarm_h_nxt = inc_hour(alarm_h);
      if (bus.inc_m_pulse) alarm_m_nxt = inc_min(alarm_m);
    end

    if (cancel) begin
      state_nxt = IDLE;
      beep_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trig) begin
            state_nxt = RINGING;
            ring_nxt  = 8'd0;
            beep_nxt  = 1'b1;
          end
        end
        RINGING: begin
          if (bus.stop_pulse) begin
            state_nxt = IDLE;
            beep_nxt  = 1'b0;
          end else if (bus.snooze_pulse) begin
            state_nxt = SNOOZE;
            snz_nxt   = SNZ_LOAD;
            beep_nxt  = 1'b0;
          end else if (bus.sec_pulse) begin
            if (ring_cnt == RING_LAST) begin
              state_nxt = IDLE;
              beep_nxt  = 1'b0;
            end else begin
              ring_nxt = ring_cnt + 8'd1;
              beep_nxt = ~beep_on;
            end
          end
        end
        SNOOZE: begin
          if (bus.stop_pulse) begin
            state_nxt = IDLE;
          end else if (bus.sec_pulse) begin
            if (snz_cnt == 10'd1) begin
              state_nxt = RINGING;
              ring_nxt  = 8'd0;
              beep_nxt  = 1'b1;
            end else begin
              snz_nxt = snz_cnt - 10'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          beep_nxt  = 1'b0;
        end
      endcase
    end

    // Tone starts high on entry so the first beep sounds at once, then toggles each cycle.
    if (state_nxt == RINGING) tone_nxt = (state == RINGING) ? ~tone : 1'b1;
    else                      tone_nxt = 1'b0;

    buzzer_nxt = beep_nxt & (TONE_EN ? tone_nxt : 1'b1);
  end

  always_ff @(posedge clk_ac) begin
    if (!rst_n) begin
      alarm_h    <= 8'h07;
      alarm_m    <= 8'h00;
      state      <= IDLE;
      ring_cnt   <= 8'd0;
      snz_cnt    <= 10'd0;
      beep_on    <= 1'b0;
      tone       <= 1'b0;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb block.
      alarm_h    <= alarm_h_nxt;
      alarm_m    <= alarm_m_nxt;
      state      <= state_nxt;
      ring_cnt   <= ring_nxt;
      snz_cnt    <= snz_nxt;
      beep_on    <= beep_nxt;
      tone       <= tone_nxt;
      buzzer_q   <= buzzer_nxt;
      ringing_q  <= (state_nxt == RINGING);
      snoozing_q <= (state_nxt == SNOOZE);
    end
  end

  assign bus.alarm_bcd16 = {alarm_h, alarm_m};
  assign bus.buzzer      = buzzer_q;
  assign bus.ringing     = ringing_q;
  assign bus.snoozing    = snoozing_q;

endmodule

// File: tb/tb_alarm_unit_bcd.sv
// Directed bench for alarm_unit_bcd (TONE_EN=0): expectations are queued when stimulus
// is driven and compared one cycle later, just after the clock edge.
module tb_alarm_unit_bcd;

  logic clk_ac = 1'b0;
  logic rst_n;
  always #5 clk_ac = ~clk_ac;

  alarm_unit_bcd_if bus();

  alarm_unit_bcd #(
    .SNOOZE_MIN (5),
    .RING_SEC   (60),
    .TONE_EN    (1'b0)
  ) dut (
    .clk_ac (clk_ac),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef enum {O_ALARM, O_BUZ, O_RING, O_SNZ} out_e;
  typedef struct {
    string       tag;
    out_e        sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   t_sec  = 0;
  int   al_h   = 7;
  int   al_m   = 0;

  function automatic logic [23:0] to_bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] alarm_model();
    return {4'(al_h / 10), 4'(al_h % 10), 4'(al_m / 10), 4'(al_m % 10)};
  endfunction

  function automatic logic [15:0] observe(input out_e s);
    case (s)
      O_ALARM: return bus.alarm_bcd16;
      O_BUZ:   return {15'd0, bus.buzzer};
      O_RING:  return {15'd0, bus.ringing};
      default: return {15'd0, bus.snoozing};
    endcase
  endfunction

  task automatic expect_out(input string tag, input out_e sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic expect_flags(input string tag, input bit r, input bit b, input bit s);
    expect_out(tag, O_RING, {15'd0, r});
    expect_out(tag, O_BUZ,  {15'd0, b});
    expect_out(tag, O_SNZ,  {15'd0, s});
  endtask

  task automatic check();
    exp_t        e;
    logic [15:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s.%s observed=%h expected=%h", e.tag, e.sel.name(), o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_ac);
    #1;
    check();
  endtask

  task automatic set_time(input int t);
    t_sec = t;
    bus.time_bcd24 = to_bcd(t);
  endtask

  // One second: pulse cycle then a quiet cycle, outputs expected stable across both.
  task automatic sec_step(input string tag, input bit r, input bit b, input bit s);
    set_time((t_sec + 1) % 86400);
    bus.sec_pulse = 1'b1;
    expect_flags(tag, r, b, s);
    tick();
    bus.sec_pulse = 1'b0;
    expect_flags({tag, "_hold"}, r, b, s);
    tick();
  endtask

  task automatic pulse_stop_snooze(input string tag, input bit stp, input bit snz,
                                   input bit r, input bit b, input bit s);
    bus.stop_pulse   = stp;
    bus.snooze_pulse = snz;
    expect_flags(tag, r, b, s);
    tick();
    bus.stop_pulse   = 1'b0;
    bus.snooze_pulse = 1'b0;
  endtask

  task automatic edit_step(input bit ih, input bit im);
    bus.inc_h_pulse = ih;
    bus.inc_m_pulse = im;
    if (ih) al_h = (al_h + 1) % 24;
    if (im) al_m = (al_m + 1) % 60;
    expect_out("alarm_edit", O_ALARM, alarm_model());
    tick();
    bus.inc_h_pulse = 1'b0;
    bus.inc_m_pulse = 1'b0;
  endtask

  task automatic set_alarm(input int h, input int m);
    bus.alarm_set = 1'b1;
    while (al_h != h || al_m != m) edit_step(al_h != h, al_m != m);
    bus.alarm_set = 1'b0;
  endtask

  task automatic trigger(input string tag);
    set_time(7 * 3600 - 1);
    sec_step(tag, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    bus.time_bcd24   = 24'h0;
    bus.sec_pulse    = 1'b0;
    bus.alarm_en     = 1'b0;
    bus.alarm_set    = 1'b0;
    bus.inc_h_pulse  = 1'b0;
    bus.inc_m_pulse  = 1'b0;
    bus.snooze_pulse = 1'b0;
    bus.stop_pulse   = 1'b0;

    // Reset
    tick();
    expect_out("reset", O_ALARM, 16'h0700);
    expect_flags("reset", 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Alarm edit: 17 hour steps (23->00 wrap) then 61 minute steps (59->00, no carry)
    bus.alarm_set = 1'b1;
    for (int i = 0; i < 17; i++) edit_step(1'b1, 1'b0);
    for (int i = 0; i < 61; i++) edit_step(1'b0, 1'b1);
    expect_out("edit_final", O_ALARM, 16'h0001);
    tick();
    set_alarm(7, 0);
    bus.inc_h_pulse = 1'b1;
    bus.inc_m_pulse = 1'b1;
    expect_out("inc_ignored", O_ALARM, 16'h0700);
    tick();
    bus.inc_h_pulse = 1'b0;
    bus.inc_m_pulse = 1'b0;

    // No false triggers
    bus.alarm_en = 1'b1;
    set_time(7 * 3600);
    expect_flags("no_sec_pulse", 1'b0, 1'b0, 1'b0);
    tick();
    set_time(7 * 3600 + 4);
    sec_step("sec_05", 1'b0, 1'b0, 1'b0);
    bus.alarm_en = 1'b0;
    set_time(7 * 3600 - 1);
    sec_step("disarmed", 1'b0, 1'b0, 1'b0);
    bus.alarm_en  = 1'b1;
    bus.alarm_set = 1'b1;
    set_time(7 * 3600 - 1);
    sec_step("set_mode", 1'b0, 1'b0, 1'b0);
    bus.alarm_set = 1'b0;

    // Ring for exactly 60 s, 1 s on / 1 s off
    set_time(7 * 3600 - 2);
    sec_step("pre_alarm", 1'b0, 1'b0, 1'b0);
    sec_step("trigger", 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 60; k++)
      sec_step($sformatf("ring_%0d", k), k < 60, (k < 60) && (k % 2 == 0), 1'b0);

    // Snooze for 300 s then ring again; snooze_pulse is ignored while snoozing
    trigger("trig2");
    sec_step("trig2_s1", 1'b1, 1'b0, 1'b0);
    pulse_stop_snooze("snooze", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_stop_snooze("snooze_again", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 300; k++)
      sec_step($sformatf("snz_%0d", k), k == 300, k == 300, k < 300);
    sec_step("rering_s1", 1'b1, 1'b0, 1'b0);
    pulse_stop_snooze("stop_ring", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stop beats snooze in the same cycle
    trigger("trig3");
    pulse_stop_snooze("stop_and_snooze", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stop while snoozing
    trigger("trig4");
    pulse_stop_snooze("snooze4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_stop_snooze("stop_snooze", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Disarm during snooze
    trigger("trig5");
    pulse_stop_snooze("snooze5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.alarm_en = 1'b0;
    expect_flags("disarm_snooze", 1'b0, 1'b0, 1'b0);
    tick();
    bus.alarm_en = 1'b1;
    sec_step("rearmed_idle", 1'b0, 1'b0, 1'b0);

    // Entering edit mode while ringing
    trigger("trig6");
    bus.alarm_set = 1'b1;
    expect_flags("set_while_ring", 1'b0, 1'b0, 1'b0);
    expect_out("set_while_ring", O_ALARM, 16'h0700);
    tick();
    bus.alarm_set = 1'b0;
    sec_step("after_set", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
